horner_sequencer: RTL and testbench

Control FSM that sequences the shared Mul_Sum datapath (constant mux, two input muxes, Accum0/Accum1, output register) to evaluate y = c0*x^DEGREE + c1*x^(DEGREE-1) + ... + cDEGREE by Horner's scheme. It drives every mux select, the multiply/add select, the register enables and the status flags. The datapath is untouched; this block replaces hard-wired sequencing with a parameterised, handshaken sequencer.

---
 rtl/horner_sequencer_if.sv | 27 ++
 rtl/horner_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_horner_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/horner_sequencer_if.sv
// Control bundle between the Horner sequencer (master) and the Mul_Sum datapath / requester (slave).
interface horner_sequencer_if;
    logic       start;
    logic       ovf;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] coef_sel;
    logic [1:0] i0_sel;
    logic [1:0] i1_sel;
    logic       ms_op;
    logic       acc0_en;
    logic       acc1_en;
    logic       or_en;

    modport master (
        input  start, ovf,
        output busy, done, error, coef_sel, i0_sel, i1_sel,
               ms_op, acc0_en, acc1_en, or_en
    );

    modport slave (
        output start, ovf,
        input  busy, done, error, coef_sel, i0_sel, i1_sel,
               ms_op, acc0_en, acc1_en, or_en
    );
endinterface

// File: rtl/horner_sequencer.sv
// Sequencer that drives the shared Mul_Sum datapath through Horner evaluation of a DEGREE polynomial.
// Optional macro OVF_CHECK_EN: datapath overflow in INIT/ADD/MUL sets the sticky error flag.
module horner_sequencer #(
    parameter int WORD_LENGTH = 8,
    parameter int DEGREE      = 2
) (
    input  logic                clk,
    input  logic                reset,
    horner_sequencer_if.master  bus
);

    generate
        if (DEGREE < 1 || DEGREE > 3 || WORD_LENGTH < 1) begin : g_param_check
            $error("horner_sequencer: DEGREE must be 1..3 and WORD_LENGTH >= 1");
        end
    endgenerate

    localparam logic [1:0] DEG_K = 2'(DEGREE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_INIT,
        S_ADD,
        S_MUL,
        S_WRITE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [1:0] coef_sel;
        logic [1:0] i0_sel;
        logic [1:0] i1_sel;
        logic       ms_op;
        logic       acc0_en;
        logic       acc1_en;
        logic       or_en;
        logic       busy;
        logic       done;
    } ctrl_t;

    state_t     state_reg;
    logic [1:0] k_reg;
    ctrl_t      ctrl_reg;
    logic       error_reg;

    logic accept;
    logic start_busy;
    logic ovf_hit;

    // Outputs are registered, so every transition loads the control word of the state being entered.
    function automatic ctrl_t decode(input state_t s, input logic [1:0] k);
        ctrl_t c;
        c = '0;
        case (s)
            S_LATCH: begin
                c.i0_sel  = 2'b11;
                c.i1_sel  = 2'b00;
                c.acc1_en = 1'b1;
                c.busy    = 1'b1;
            end
            S_INIT: begin
                c.i0_sel  = 2'b00;
                c.i1_sel  = 2'b10;
                c.ms_op   = 1'b1;
                c.acc0_en = 1'b1;
                c.busy    = 1'b1;
            end
            S_ADD: begin
                c.coef_sel = k;
                c.i0_sel   = 2'b00;
                c.i1_sel   = 2'b01;
                c.acc0_en  = 1'b1;
                c.busy     = 1'b1;
            end
            S_MUL: begin
                c.i0_sel  = 2'b10;
                c.i1_sel  = 2'b10;
                c.ms_op   = 1'b1;
                c.acc0_en = 1'b1;
                c.busy    = 1'b1;
            end
            S_WRITE: begin
                c.or_en = 1'b1;
                c.busy  = 1'b1;
            end
            S_DONE: begin
                c.done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign accept     = bus.start && !ctrl_reg.busy;
    assign start_busy = bus.start && ctrl_reg.busy;

`ifdef OVF_CHECK_EN
    assign ovf_hit = bus.ovf && (state_reg == S_INIT || state_reg == S_ADD || state_reg == S_MUL);
`else
    // Port stays in the build; its value never reaches the error flag.
    assign ovf_hit = 1'b0 & bus.ovf;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            k_reg     <= 2'd0;
            ctrl_reg  <= '0;
            error_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        state_reg <= S_LATCH;
                        k_reg     <= 2'd0;
                        ctrl_reg  <= decode(S_LATCH, 2'd0);
                    end else begin
                        ctrl_reg  <= decode(S_IDLE, 2'd0);
                    end
                end
                S_LATCH: begin
                    state_reg <= S_INIT;
                    ctrl_reg  <= decode(S_INIT, 2'd0);
                end
                S_INIT: begin
                    state_reg <= S_ADD;
                    k_reg     <= 2'd1;
                    ctrl_reg  <= decode(S_ADD, 2'd1);
                end
                S_ADD: begin
                    if (k_reg == DEG_K) begin
                        state_reg <= S_WRITE;
                        ctrl_reg  <= decode(S_WRITE, 2'd0);
                    end else begin
                        state_reg <= S_MUL;
                        ctrl_reg  <= decode(S_MUL, 2'd0);
                    end
                end
                S_MUL: begin
                    state_reg <= S_ADD;
                    k_reg     <= k_reg + 2'd1;
                    ctrl_reg  <= decode(S_ADD, k_reg + 2'd1);
                end
                S_WRITE: begin
                    state_reg <= S_DONE;
                    ctrl_reg  <= decode(S_DONE, 2'd0);
                end
                S_DONE: begin
                    if (bus.start) begin
                        state_reg <= S_LATCH;
                        k_reg     <= 2'd0;
                        ctrl_reg  <= decode(S_LATCH, 2'd0);
                    end else begin
                        state_reg <= S_IDLE;
                        ctrl_reg  <= decode(S_IDLE, 2'd0);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    k_reg     <= 2'd0;
                    ctrl_reg  <= '0;
                end
            endcase

            // An accepted start opens a fresh run with a clean flag; otherwise the flag only accumulates.
            if (accept) begin
                error_reg <= 1'b0;
            end else if (start_busy || ovf_hit) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign bus.coef_sel = ctrl_reg.coef_sel;
    assign bus.i0_sel   = ctrl_reg.i0_sel;
    assign bus.i1_sel   = ctrl_reg.i1_sel;
    assign bus.ms_op    = ctrl_reg.ms_op;
    assign bus.acc0_en  = ctrl_reg.acc0_en;
    assign bus.acc1_en  = ctrl_reg.acc1_en;
    assign bus.or_en    = ctrl_reg.or_en;
    assign bus.busy     = ctrl_reg.busy;
    assign bus.done     = ctrl_reg.done;
    assign bus.error    = error_reg;

endmodule

// File: tb/tb_horner_sequencer.sv
// Bench: Mul_Sum datapath model driven by the sequencer, scoreboard of polynomial results, error and latency.
module tb_horner_sequencer;

    localparam int DEG = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    horner_sequencer_if bus();

    horner_sequencer #(.WORD_LENGTH(8), .DEGREE(DEG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Datapath model: constant mux, two input muxes, Mul_Sum, Accum0/Accum1, output register.
    logic [7:0]  coef [0:3];
    logic [7:0]  x_input = 8'd0;
    logic [7:0]  acc0 = 8'd0;
    logic [7:0]  acc1 = 8'd0;
    logic [7:0]  y_out = 8'd0;
    logic [15:0] in0, in1, full;
    logic        dp_ovf;

    always_comb begin
        in0 = 16'd0;
        in1 = 16'd0;
        case (bus.i0_sel)
            2'b00: in0 = {8'd0, coef[bus.coef_sel]};
            2'b01: in0 = {8'd0, x_input};
            2'b10: in0 = {8'd0, acc0};
            default: in0 = 16'd0;
        endcase
        case (bus.i1_sel)
            2'b00: in1 = {8'd0, x_input};
            2'b01: in1 = {8'd0, acc0};
            2'b10: in1 = {8'd0, acc1};
            default: in1 = 16'd0;
        endcase
        full   = bus.ms_op ? in0 * in1 : in0 + in1;
        dp_ovf = bus.acc0_en && (full[15:8] != 8'd0);
    end

    assign bus.ovf = dp_ovf;

    always @(posedge clk) begin
        if (bus.acc0_en) acc0 <= full[7:0];
        if (bus.acc1_en) acc1 <= full[7:0];
        if (bus.or_en)   y_out <= acc0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] y;
        bit         err;
        int         start_cyc;
    } exp_t;

    exp_t sb [$];
    int total = 0;
    int bad   = 0;

`ifdef OVF_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    // busy, done, coef_sel, i0_sel, i1_sel, ms_op, acc0_en, acc1_en, or_en
    localparam logic [11:0] TRACE_EXP [0:6] = '{
        12'b1_0_00_11_00_0_0_1_0,   // LATCH
        12'b1_0_00_00_10_1_1_0_0,   // INIT
        12'b1_0_01_00_01_0_1_0_0,   // ADD k=1
        12'b1_0_00_10_10_1_1_0_0,   // MUL
        12'b1_0_10_00_01_0_1_0_0,   // ADD k=2
        12'b1_0_00_00_00_0_0_0_1,   // WRITE
        12'b0_1_00_00_00_0_0_0_0    // DONE
    };

    function automatic logic [11:0] ctl_word();
        return {bus.busy, bus.done, bus.coef_sel, bus.i0_sel, bus.i1_sel,
                bus.ms_op, bus.acc0_en, bus.acc1_en, bus.or_en};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the polynomial value itself, modulo 256.
    function automatic logic [7:0] ref_y();
        longint sum = 0;
        for (int k = 0; k <= DEG; k++) begin
            longint p = 1;
            for (int j = 0; j < DEG - k; j++) p = p * x_input;
            sum = sum + longint'(coef[k]) * p;
        end
        return 8'(sum % 256);
    endfunction

    // Whether any Horner step (c0*x, then +ck, *x ...) exceeds 8 bits.
    function automatic bit ref_ovf();
        int acc = int'(coef[0]) * int'(x_input);
        bit ov = (acc > 255);
        acc = acc % 256;
        for (int k = 1; k <= DEG; k++) begin
            acc = acc + int'(coef[k]);
            if (acc > 255) ov = 1'b1;
            acc = acc % 256;
            if (k < DEG) begin
                acc = acc * int'(x_input);
                if (acc > 255) ov = 1'b1;
                acc = acc % 256;
            end
        end
        return ov;
    endfunction

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && bus.done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending run (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("y_output", int'(y_out), int'(e.y));
                check("error_at_done", int'(bus.error), int'(e.err));
                check("latency", cyc - e.start_cyc, 2 * DEG + 3);
                check("busy_at_done", int'(bus.busy), 0);
                $display("run: x=%0d y=%0d exp_y=%0d err=%0b exp_err=%0b", x_input, y_out, e.y, bus.error, e.err);
            end
        end
    end

    // Called right after a negedge; start is raised in this cycle. Returns at the negedge showing done.
    task automatic run_one(input logic [7:0] xv, input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input int busy_at, input bit trace);
        exp_t e;
        bit   seen;
        coef[0] = c0;
        coef[1] = c1;
        coef[2] = c2;
        coef[3] = 8'd0;
        x_input = xv;
        bus.start = 1'b1;
        e.y = ref_y();
        e.err = OVF_EN && ref_ovf();
        e.start_cyc = cyc;
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (trace && i <= 7) check("trace", int'(ctl_word()), int'(TRACE_EXP[i-1]));
            if (bus.done) begin
                seen = 1'b1;
                bus.start = 1'b0;
            end else begin
                bus.start = (i == busy_at);
                if (i == busy_at) begin
                    exp_t t;
                    t = sb.pop_back();
                    t.err = 1'b1;
                    sb.push_back(t);
                end
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            bus.start = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] y_before;
        bit found;
        bit stray;
        bus.start = 1'b1;
        for (int k = 0; k < 4; k++) coef[k] = 8'd0;

        // Reset held with start asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", int'({bus.error, ctl_word()}), 0);
        end
        reset = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_after_reset", int'({bus.error, ctl_word()}), 0);
        end

        // Nominal run with trace, then a back-to-back run started in the DONE cycle.
        run_one(8'd2, 8'd4, 8'd5, 8'd3, 0, 1'b1);
        run_one(8'd3, 8'd4, 8'd5, 8'd3, 0, 1'b0);
        repeat (2) @(negedge clk);

        // start during MUL flags error; the following accepted start clears it.
        run_one(8'd2, 8'd4, 8'd5, 8'd3, 4, 1'b0);
        @(negedge clk);
        check("error_sticky_idle", int'(bus.error), 1);
        run_one(8'd2, 8'd4, 8'd5, 8'd3, 0, 1'b0);
        @(negedge clk);

        // Overflowing evaluation.
        run_one(8'd10, 8'd4, 8'd5, 8'd3, 0, 1'b0);
        @(negedge clk);

        // Randomized runs, mixing back-to-back starts, idle gaps and busy starts.
        for (int n = 0; n < 40; n++) begin
            int ba;
            ba = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * DEG + 2)) : 0;
            run_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ba, 1'b0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Reset during the second ADD aborts the run.
        y_before = y_out;
        coef[0] = 8'd7; coef[1] = 8'd1; coef[2] = 8'd9; x_input = 8'd5;
        bus.start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.acc0_en && !bus.ms_op && bus.coef_sel == 2'd2) found = 1'b1;
        end
        check("second_add_reached", int'(found), 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_outputs", int'({bus.error, ctl_word()}), 0);
        reset = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.or_en || bus.busy) stray = 1'b1;
        end
        check("abort_no_done", int'(stray), 0);
        check("abort_y_hold", int'(y_out), int'(y_before));

        // Recovery after the abort.
        run_one(8'd2, 8'd4, 8'd5, 8'd3, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
